math_add_share: RTL
===================

# math_add_share

Time-shares one pipelined fabric adder (`math_add_fab`) among `NUM_REQ` requesters. A round-robin arbiter grants at most one valid/ready operand pair per cycle. A tag pipeline tracks which requester owns each in-flight sum, and a registered output stage routes each result back to its owner. The block sits between parallel accumulation engines and the single fabric adder, so multiple channels can use one adder.

## Interface
- `WIDTH`, 16, operand/sum bit width; must be a multiple of `LATENCY+1`.
- `LATENCY`, 1, pipeline latency of the `math_add_fab` instance; 0 is legal.
- `NUM_REQ`, 4, number of requesters; range 2–16.
- `ID_W`, `clog2(NUM_REQ)`, derived; requester index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ena`  in  1  global advance enable; when low, the whole block freezes.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_a`  in  `NUM_REQ*WIDTH`  operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `NUM_REQ*WIDTH`  operand B; same packing as `req_a`.
- `req_ready`  out  `NUM_REQ`  grant; combinational, one-hot or zero.
- `res_valid`  out  `NUM_REQ`  one-hot result strobe; registered.
- `res_id`  out  `ID_W`  owner index of the current result; registered.
- `res_data`  out  `WIDTH`  sum, wrapping signed A+B mod 2^WIDTH; registered.
- `busy`  out  1  any operation in flight or in the output register.

## Operation
- **Handshake.**
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - A requester holds `req_valid` and its operands stable until the transfer.
  - `req_ready` may depend on `req_valid`.
- **Arbitration.**
  - `req_ready = ena ? grant : 0`.
  - `grant` is the first asserted `req_valid` scanning upward, with wrap, from `last+1`.
  - `last` updates to the granted index only on a transfer.
  - Reset value of `last` is `NUM_REQ-1`, so requester 0 has first priority.
- **Issue.**
  - The granted requester's `req_a`/`req_b` are muxed onto the adder inputs in the transfer cycle.
  - With no transfer, the adder inputs are driven with 0.
- **Tag pipeline.**
  - Depth `LATENCY`; each entry is `{vld, id}`.
  - It advances only when `ena` is high and stays aligned with the adder output.
  - When `LATENCY=0`, the tag is taken directly from the issue cycle.
- **Output register.**
  - When `ena` is high, it captures `{vld, id, sum}` from the pipeline tail.
  - `res_valid = vld ? onehot(id) : 0`.
  - When `ena` is low, `res_valid` is forced to 0 and `res_id`/`res_data` hold. No result is duplicated or lost across a stall.
- **busy**: OR of all tag `vld` bits and the output `vld`.
- **Reset values.**
  - `res_valid=0`, `res_id=0`, `res_data=0`, `busy=0`, `req_ready=0` during reset.
  - All tag `vld` bits are cleared.
  - Adder data registers are not reset; stale data is harmless because `vld` is cleared.
- **Reset mid-operation.** All in-flight operations are discarded, no `res_valid` is produced for them, and `last` returns to `NUM_REQ-1`.
- **Overflow.** Sums wrap silently; no saturation and no flag.

## Timing
- Transfer in cycle t produces `res_valid[owner]=1` in cycle t+`LATENCY`+1, assuming `ena` stays high.
- Each cycle of `ena`=0 inside that window adds exactly one cycle.
- Throughput: one operation per cycle, sustained across any mix of requesters.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,`NUM_REQ`-1,0,…
- Worst-case wait for a continuously valid requester is `NUM_REQ`-1 transfers.
- A single requester that is continuously valid gets a transfer every cycle.
- Results leave in issue order; there is no reordering.

## Structure
- Shared package `math_pkg` holds:
  - the `clog2` function;
  - the `TAG_T` typedef `{logic vld; logic [ID_W-1:0] id}`.
- Sub-module `arb_rr`, parameterised by N. It takes `req`, `advance` and `ena`, and outputs a one-hot `grant` and holds the `last` pointer. It is reusable elsewhere.
- The adder is instantiated as `math_add_fab` with `ena` tied to the block `ena`.
- The tag pipeline is a local register array, not `shift_reg`, because the `vld` bits must be resettable.

## Test plan
- **Single add.** `WIDTH=16`, `LATENCY=1`. Requester 2 presents a=0x1234, b=0x0FFF at t. Expect `req_ready[2]` at t, then `res_valid=4'b0100`, `res_id=2`, `res_data=0x2233` at t+2.
- **Wrap.** a=0x7FFF, b=0x0001 → `res_data=0x8000`. a=0xFFFF, b=0xFFFF → `res_data=0xFFFE`.
- **Round-robin fairness.** All 4 requesters valid for 8 cycles. Expect the grant sequence 0,1,2,3,0,1,2,3 and results returning in the same order, one per cycle.
- **Stall.** Issue to requester 1, then drop `ena` for 3 cycles mid-flight. Expect exactly one `res_valid[1]` pulse at t+2+3 with the correct sum, and no `req_ready` while `ena`=0.
- **Reset mid-flight.** Issue 3 ops, assert `rst` one cycle later. Expect no `res_valid` afterwards and `busy`=0. The next grant with all valid goes to requester 0.
- **Parameter sweep.** `LATENCY`∈{0,1,3} with `WIDTH=16` or 24 and random traffic. A scoreboard matches each issued (id, a+b) to its result, and latency equals `LATENCY`+1 plus the number of stall cycles.

Source files
------------

// File: rtl/math_pkg.sv
// Shared math helpers: ceiling log2 and the in-flight tag record used by
// adder-sharing blocks.
package math_pkg;

  localparam int unsigned MAX_ID_W = 4;  // covers up to 16 requesters

  // Ceiling log2, never less than 1 so a requester index always has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } TAG_T;

endpackage

// File: rtl/arb_rr.sv
// Round-robin arbiter: one-hot grant to the first request above the last
// transferred index, wrapping; the pointer moves only on an accepted grant.
module arb_rr
  import math_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned LW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] last
);

  logic [LW-1:0] pick;
  logic [LW-1:0] cand;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    pick  = last;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx  = (32'(last) + off) % N;
      cand = LW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    if (found && ena && !rst) grant[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                 last <= LW'(N - 1);
    else if (ena && advance) last <= pick;
  end

endmodule

// File: rtl/math_add_fab.sv
// Pipelined fabric adder: the word is split into LATENCY+1 segments, one per
// stage, with the carry registered between stages. Data registers are not reset.
module math_add_fab #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             ena,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int unsigned NSEG = LATENCY + 1;
  localparam int unsigned CW   = WIDTH / NSEG;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [WIDTH-1:0] a_i, b_i, s_i, s_o;
    logic             c_i, c_o;

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = b;
      assign s_i = '0;
      assign c_i = 1'b0;
    end else begin : g_pipe
      always_ff @(posedge clk) begin
        if (ena) begin
          a_i <= g_seg[k-1].a_i;
          b_i <= g_seg[k-1].b_i;
          s_i <= g_seg[k-1].s_o;
          c_i <= g_seg[k-1].c_o;
        end
      end
    end

    // Segment k is summed here; lower segments are already final in s_i.
    always_comb begin
      s_o = s_i;
      {c_o, s_o[k*CW +: CW]} = {1'b0, a_i[k*CW +: CW]} + {1'b0, b_i[k*CW +: CW]}
                             + {{CW{1'b0}}, c_i};
    end
  end

  assign sum = g_seg[NSEG-1].s_o;

endmodule

// File: rtl/math_add_share.sv
// Shares one pipelined fabric adder among NUM_REQ requesters: round-robin
// issue, a resettable tag pipeline alongside the adder, registered result routing.
module math_add_share
  import math_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned LATENCY = 1,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_data,
  output logic                     busy
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    arb_last;
  logic               xfer;
  logic [ID_W-1:0]    issue_id;
  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  TAG_T               issue_tag, tail;
  logic               tag_busy;
  logic               res_vld_q;

  arb_rr #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant),
    .last    (arb_last)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // Idle cycles feed zeros so the adder sees no stale operands.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    issue_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        add_a    = req_a[i*WIDTH +: WIDTH];
        add_b    = req_b[i*WIDTH +: WIDTH];
        issue_id = ID_W'(i);
      end
    end
    issue_tag     = '0;
    issue_tag.vld = xfer;
    issue_tag.id  = MAX_ID_W'(issue_id);
  end

  math_add_fab #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_add (
    .clk (clk),
    .ena (ena),
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  if (LATENCY == 0) begin : g_tag_bypass
    assign tail     = issue_tag;
    assign tag_busy = 1'b0;
  end else begin : g_tag_pipe
    TAG_T tag_q [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else if (ena) begin
        tag_q[0] <= issue_tag;
        for (int unsigned i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
    end

    always_comb begin
      tag_busy = 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_busy = tag_busy | tag_q[i].vld;
    end

    assign tail = tag_q[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else if (ena) begin
      res_vld_q <= tail.vld;
      res_id    <= tail.id[ID_W-1:0];
      res_data  <= add_sum;
    end
  end

  // A held result is shown only in the first enabled cycle, when it is also replaced.
  always_comb begin
    res_valid = '0;
    if (res_vld_q && ena && !rst) res_valid[res_id] = 1'b1;
  end

  assign busy = !rst && (tag_busy || res_vld_q);

endmodule
